// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared definitions for the memory-mapped UART transmitter:
//                register offsets (addr[3:2]), STATUS bit positions, the
//                transmit FSM state type and the divisor clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] c_reg_data   = 2'd0;
  localparam logic [1:0] c_reg_status = 2'd1;
  localparam logic [1:0] c_reg_div    = 2'd2;
  localparam logic [1:0] c_reg_rsvd   = 2'd3;

  // STATUS register bit positions
  localparam int c_stat_busy  = 0;
  localparam int c_stat_full  = 1;
  localparam int c_stat_empty = 2;
  localparam int c_stat_ovf   = 3;

  // Smallest bit-period divisor the baud counter supports
  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock fall-through FIFO. pop_data always shows the
//                head entry. A push while full is accepted when a pop happens
//                in the same cycle (the freed slot is reused at once).
//  Ports       : clk, reset_n (async, active-low)
//                push / push_data  - enqueue request and data
//                pop  / pop_data   - dequeue request and head data
//                full / empty      - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int             c_aw    = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  // When full, the slot under the write pointer is the one being popped,
  // so a simultaneous push can take it.
  assign w_do_push = push && (!full || w_do_pop);
  assign pop_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_periph
//  Description : Memory-mapped 8N1 UART transmitter for the FemtoRV32 bus.
//                Firmware pushes bytes into a TX FIFO; a baud-rate FSM
//                serialises them on tx, LSB first.
//  Ports       : clk, reset_n (async, active-low)
//                sel    - device select
//                addr   - byte offset, [3:2] selects DATA/STATUS/DIV/reserved
//                wdata  - write data, wstrb - byte write strobes
//                rstrb  - read strobe, rdata - registered read data
//                tx     - serial line, idles high
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        rstrb,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int          c_div_raw   = CLK_HZ / BAUD;
  localparam logic [15:0] c_div_reset = (c_div_raw < 2) ? DIV_MIN : 16'(c_div_raw);

  // --------------------------------------------------------------------------
  // Register decode
  // --------------------------------------------------------------------------
  logic [1:0]  w_reg;
  logic        w_data_push;
  logic        w_ovf_clr;
  logic        w_div_wr;
  logic [15:0] w_div_next;

  logic [15:0] r_div;
  logic        r_ovf;

  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_pop;
  logic [7:0]  w_fifo_dout;

  tx_state_t   r_state;
  logic [15:0] r_div_lat;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        w_bit_end;
  logic        w_busy;

  assign w_reg       = addr[3:2];
  assign w_data_push = sel && wstrb[0] && (w_reg == c_reg_data);
  assign w_ovf_clr   = sel && wstrb[0] && (w_reg == c_reg_status);
  assign w_div_wr    = sel && (|wstrb[1:0]) && (w_reg == c_reg_div);
  assign w_div_next  = {wstrb[1] ? wdata[15:8] : r_div[15:8],
                        wstrb[0] ? wdata[7:0]  : r_div[7:0]};

  // Bits the register map never looks at
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, addr[1:0], wdata[31:16], wstrb[3:2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= c_div_reset;
    end else if (w_div_wr) begin
      r_div <= clamp_div(w_div_next);
    end
  end

  // A push is lost only if the FIFO is full and nothing leaves this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end else if (w_data_push && w_fifo_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  assign w_busy = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (sel && rstrb) begin
      rdata <= '0;
      case (w_reg)
        c_reg_status: begin
          rdata[c_stat_busy]  <= w_busy;
          rdata[c_stat_full]  <= w_fifo_full;
          rdata[c_stat_empty] <= w_fifo_empty;
          rdata[c_stat_ovf]   <= r_ovf;
        end
        c_reg_div: rdata[15:0] <= r_div;
        default:   rdata <= '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  assign w_pop = (r_state == ST_IDLE) && !w_fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_data_push),
    .push_data (wdata[7:0]),
    .pop       (w_pop),
    .pop_data  (w_fifo_dout),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Serialiser FSM: baud counter, bit counter and line driver
  // --------------------------------------------------------------------------
  // The divisor is latched at frame start so DIV writes never disturb a
  // frame already on the line.
  assign w_bit_end = (r_baud_cnt == r_div_lat - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      tx         <= 1'b1;
      r_div_lat  <= c_div_reset;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (!w_fifo_empty) begin
            r_shift    <= w_fifo_dout;
            r_div_lat  <= r_div;
            r_baud_cnt <= '0;
            tx         <= 1'b0;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            tx         <= r_shift[0];
            r_state    <= ST_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              tx      <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              // Next bit is shift[1]; shift right so it becomes shift[0]
              tx        <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end
        default: begin
          tx      <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_periph
//  Description : Self-checking bench for uart_tx_periph. Expected frames and
//                read data are queued as stimulus is issued; independent
//                monitors decode the tx line and the read port and compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_periph;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        sel = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        rstrb = 1'b0;
  logic [31:0] rdata;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_periph #(
    .CLK_HZ     (12_000_000),
    .BAUD       (115_200),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sel     (sel),
    .addr    (addr),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rstrb   (rstrb),
    .rdata   (rdata),
    .tx      (tx)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    int         exp_start;   // cycle of the start bit, -1 = unconstrained
  } frame_t;

  frame_t      exp_q[$];
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_wr_edge = 0;
  bit mon_busy   = 1'b0;
  bit rd_fire    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_fire <= sel && rstrb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line level of bit slot j of an 8N1 frame: start, 8 data LSB first, stop
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // ---------------- read-port monitor ----------------
  always @(negedge clk) begin
    if (rd_fire) begin
      if (rd_exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no read", rdata);
      end else begin
        check(rd_name_q.pop_front(), rdata, rd_exp_q.pop_front());
      end
    end
  end

  // ---------------- tx-line monitor ----------------
  frame_t     mf;
  int         t0;
  int         wait_n;
  bit         bad;
  bit         aborted;
  logic [7:0] got;

  initial begin : tx_monitor
    forever begin
      @(negedge clk);
      if (reset_n && tx === 1'b0) begin
        t0 = cyc;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, expected none", t0);
          wait_n = 0;
          while (tx === 1'b0 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
          end
        end else begin
          mf = exp_q.pop_front();
          mon_busy = 1'b1;
          if (mf.exp_start >= 0) check("frame_start", t0, mf.exp_start);
          bad = 1'b0;
          aborted = 1'b0;
          got = '0;
          for (int i = 0; i < 10 * mf.div; i++) begin
            if (i > 0) @(negedge clk);
            if (!reset_n) begin
              aborted = 1'b1;
              break;
            end
            if (tx !== frame_bit(mf.data, i / mf.div)) bad = 1'b1;
            if ((i % mf.div) == mf.div / 2 && i / mf.div >= 1 && i / mf.div <= 8)
              got[i / mf.div - 1] = tx;
          end
          if (!aborted) begin
            compared++;
            if (bad || got !== mf.data) begin
              mismatched++;
              $display("FAIL frame_shape: got byte 0x%0h (bit errors %0d), expected byte 0x%0h div %0d from cycle %0d",
                       got, bad, mf.data, mf.div, t0);
            end
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; wstrb = s;
    @(posedge clk);
    #1;
    last_wr_edge = cyc;
    sel = 1'b0; wstrb = '0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    sel = 1'b1; rstrb = 1'b1; addr = a;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    @(posedge clk);
    #1;
    sel = 1'b0; rstrb = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] b, input int div, input int es);
    frame_t f;
    f.data = b;
    f.div = div;
    f.exp_start = es;
    exp_q.push_back(f);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      compared++;
      mismatched++;
      $display("FAIL wait_idle_timeout: got %0d frames pending, expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [31:0] r32;
  logic [7:0]  b8;
  int          s0;
  int          dv;
  int          dc;
  int          nb;

  initial begin : stim
    #1 reset_n = 1'b0;
    #2;
    check("reset_tx", tx, 1);
    check("reset_rdata", rdata, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    rd(4'h4, 32'h4, "status_after_reset");
    rd(4'h8, 32'd104, "div_after_reset");
    repeat (3) @(negedge clk);
    check("rdata_hold", rdata, 32'd104);
    @(negedge clk);
    sel = 1'b0; rstrb = 1'b1; addr = 4'h4;
    @(posedge clk);
    #1 rstrb = 1'b0;
    check("rdata_unselected_read", rdata, 32'd104);

    // Reserved offset and DATA reads
    wr(4'hC, 32'hFFFF_FFFF, 4'hF);
    rd(4'hC, 32'h0, "reserved_read");
    rd(4'h0, 32'h0, "data_read");
    rd(4'h8, 32'd104, "div_after_reserved_write");

    // Divisor clamp
    wr(4'h8, 32'h1, 4'h3);
    rd(4'h8, 32'd2, "div_clamp_1");
    wr(4'h8, 32'h0, 4'h1);
    rd(4'h8, 32'd2, "div_clamp_0");

    // Single frame, DIV=4
    wr(4'h8, 32'd4, 4'h3);
    wr(4'h0, 32'hA5, 4'h1);
    push_frame(8'hA5, 4, last_wr_edge + 1);
    repeat (6) @(negedge clk);
    rd(4'h4, 32'h5, "status_busy_in_frame");
    wait_idle(200);
    rd(4'h4, 32'h4, "status_after_frame");

    // Overflow: first byte popped at once, four more fill the FIFO, sixth drops
    for (int i = 0; i < 6; i++) begin
      r32 = $urandom;
      wr(4'h0, r32, 4'h1);
      if (i == 0) s0 = last_wr_edge + 1;
      if (i < 5) push_frame(r32[7:0], 4, s0 + i * 41);
    end
    rd(4'h4, 32'hB, "status_overflow");
    wr(4'h4, 32'h0, 4'h1);
    rd(4'h4, 32'h3, "status_overflow_cleared");
    wait_idle(400);

    // DIV change mid-frame affects only the next frame
    wr(4'h0, 32'h3C, 4'h1);
    s0 = last_wr_edge + 1;
    push_frame(8'h3C, 4, s0);
    wr(4'h0, 32'hC3, 4'h1);
    push_frame(8'hC3, 8, s0 + 41);
    repeat (10) @(negedge clk);
    wr(4'h8, 32'd8, 4'h3);
    rd(4'h8, 32'd8, "div_write_mid_frame");
    wait_idle(400);

    // Two queued bytes at DIV=3: starts 31 cycles apart
    wr(4'h8, 32'd3, 4'h3);
    wr(4'h0, 32'h81, 4'h1);
    s0 = last_wr_edge + 1;
    push_frame(8'h81, 3, s0);
    wr(4'h0, 32'h7E, 4'h1);
    push_frame(8'h7E, 3, s0 + 31);
    wait_idle(200);

    // Randomised batches
    for (int b = 0; b < 6; b++) begin
      dv = $urandom_range(0, 7);
      dc = (dv < 2) ? 2 : dv;
      r32 = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        wr(4'h8, {r32[31:16], 8'h00, 8'(dv)}, 4'b0011);
      end else begin
        wr(4'h8, {r32[31:8], 8'(dv)}, 4'b0001);
        wr(4'h8, {r32[31:16], 8'h00, r32[7:0]}, 4'b0010);
      end
      rd(4'h8, 32'(dc), "div_readback");
      nb = $urandom_range(1, 5);
      for (int k = 0; k < nb; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        r32 = $urandom;
        b8 = r32[7:0];
        wr(4'h0, r32, 4'h1);
        if (k == 0) s0 = last_wr_edge + 1;
        push_frame(b8, dc, s0 + k * (10 * dc + 1));
      end
      wait_idle(600);
    end

    // Reset in the middle of the data bits
    wr(4'h8, 32'd4, 4'h3);
    wr(4'h0, 32'h00, 4'h1);
    s0 = last_wr_edge + 1;
    push_frame(8'h00, 4, s0);
    wr(4'h0, 32'h00, 4'h1);
    wr(4'h0, 32'h00, 4'h1);
    while (cyc < s0 + 12) @(negedge clk);
    check("tx_mid_data", tx, 0);
    #2 reset_n = 1'b0;
    #1 check("tx_async_reset", tx, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(4'h4, 32'h4, "status_after_midframe_reset");
    rd(4'h8, 32'd104, "div_after_midframe_reset");
    repeat (60) @(negedge clk);
    check("tx_idle_after_reset", tx, 1);

    repeat (3) @(negedge clk);
    if (rd_exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL rd_pending: got %0d reads unanswered, expected 0", rd_exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
